// File: rtl/wired_inst_buffer.sv
// ---------------------------------------------------------------------------------------------
// wired_inst_buffer
//
// Two-wide, in-order instruction queue between the frontend and the decode stage. It absorbs
// fetch bubbles and decode stalls. Each lane carries an opaque payload (pc, inst, exception and
// interrupt tag) that is stored and forwarded unchanged.
//
// Entries are compacted on enqueue: a single valid lane, lane0 or lane1, always lands in one
// slot at the write pointer. Decode sees the oldest entry on lane0 and the next-oldest entry on
// lane1. It consumes every flagged lane whenever out_ready_i is high.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; takes priority over flush_i
//   flush_i      backend redirect; empties the queue and drops this cycle's enqueue and dequeue
//   in_valid_i   per-lane valid from the frontend; lane0 is older
//   in_data_i    lane0 payload in [DATA_W-1:0], lane1 payload in the upper half
//   in_ready_o   a full two-lane packet fits; depends only on the registered count
//   out_valid_o  decode lanes valid; bit 1 set implies bit 0 set
//   out_data_o   oldest entry on lane0, next-oldest entry on lane1
//   out_ready_i  decode takes every lane flagged in out_valid_o
//   count_o      current occupancy, 0..DEPTH
// ---------------------------------------------------------------------------------------------
module wired_inst_buffer #(
   parameter int unsigned DEPTH  = 8,   // power of two, at least 4
   parameter int unsigned DATA_W = 72
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush_i,
   input  logic [1:0]              in_valid_i,
   input  logic [2*DATA_W-1:0]     in_data_i,
   output logic                    in_ready_o,
   output logic [1:0]              out_valid_o,
   output logic [2*DATA_W-1:0]     out_data_o,
   input  logic                    out_ready_i,
   output logic [$clog2(DEPTH):0]  count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   localparam logic [CntW-1:0] CntDepth  = CntW'(DEPTH);
   // Largest occupancy that still leaves room for a full two-lane packet.
   localparam logic [CntW-1:0] CntMaxEnq = CntW'(DEPTH - 2);

   // ------------------------------------------------------------------------------------------
   // Storage and state
   // ------------------------------------------------------------------------------------------
   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   logic [PtrW-1:0] wr_ptr_p1;
   logic [PtrW-1:0] rd_ptr_p1;

   logic [DATA_W-1:0] in_lane0, in_lane1;
   logic [DATA_W-1:0] wdata0, wdata1;
   logic              we0, we1;

   logic       enq;
   logic       deq;
   logic [1:0] n_in;
   logic [1:0] n_out;

   // ------------------------------------------------------------------------------------------
   // Status outputs: driven only from registered occupancy, so there is no combinational
   // path from in_valid_i or out_ready_i to in_ready_o.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      in_ready_o     = (cnt_q <= CntMaxEnq);
      out_valid_o[0] = (cnt_q != '0);
      out_valid_o[1] = (cnt_q > CntW'(1));
      count_o        = cnt_q;
   end

   // ------------------------------------------------------------------------------------------
   // Read side: a combinational read of the two oldest slots. The second slot wraps modulo
   // DEPTH via the natural pointer width.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      rd_ptr_p1  = rd_ptr_q + PtrW'(1);
      out_data_o = {mem_q[rd_ptr_p1], mem_q[rd_ptr_q]};
   end

   // ------------------------------------------------------------------------------------------
   // Write side with compaction. With a single valid lane, that lane's payload goes to wr_ptr.
   // With both lanes valid, lane0 goes to wr_ptr and lane1 to wr_ptr+1.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      in_lane0  = in_data_i[DATA_W-1:0];
      in_lane1  = in_data_i[2*DATA_W-1:DATA_W];
      wr_ptr_p1 = wr_ptr_q + PtrW'(1);

      // Flush and reset drop the incoming packet, so it must not touch the RAM either.
      enq = in_ready_o & (|in_valid_i) & ~flush_i & ~rst;

      wdata0 = in_valid_i[0] ? in_lane0 : in_lane1;
      wdata1 = in_lane1;
      we0    = enq;
      we1    = enq & (&in_valid_i);

      n_in = enq ? ({1'b0, in_valid_i[0]} + {1'b0, in_valid_i[1]}) : 2'd0;
   end

   // ------------------------------------------------------------------------------------------
   // Dequeue: decode takes every valid lane at once. With nothing valid, out_ready_i does
   // nothing.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      deq   = out_ready_i & out_valid_o[0];
      n_out = deq ? ({1'b0, out_valid_o[0]} + {1'b0, out_valid_o[1]}) : 2'd0;
   end

   // ------------------------------------------------------------------------------------------
   // Next-state pointers and occupancy. A flush collapses the queue onto the write pointer,
   // which cancels any enqueue or dequeue in the same cycle.
   // ------------------------------------------------------------------------------------------
   always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(n_in);
      rd_ptr_d = rd_ptr_q + PtrW'(n_out);
      cnt_d    = cnt_q + CntW'(n_in) - CntW'(n_out);

      if (flush_i) begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = wr_ptr_q;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // The payload RAM is not reset; a slot's contents only matter once occupancy covers it.
   always_ff @(posedge clk) begin
      if (we0) begin
         mem_q[wr_ptr_q] <= wdata0;
      end
      if (we1) begin
         mem_q[wr_ptr_p1] <= wdata1;
      end
   end

   // ------------------------------------------------------------------------------------------
   // Invariants
   // ------------------------------------------------------------------------------------------
   cnt_bound_a : assert property (@(posedge clk) disable iff (rst) cnt_q <= CntDepth);

   ptr_cnt_a : assert property (@(posedge clk) disable iff (rst)
      PtrW'(wr_ptr_q - rd_ptr_q) == cnt_q[PtrW-1:0]);

   no_ovf_write_a : assert property (@(posedge clk) disable iff (rst) we0 |-> in_ready_o);

endmodule

// File: tb/tb_wired_inst_buffer.sv
// ---------------------------------------------------------------------------------------------
// tb_wired_inst_buffer
//
// Testbench for wired_inst_buffer. A reference queue of payload words models the buffer
// contents. On each rising edge, the model drops everything on reset or flush. Otherwise it pops
// what decode takes and appends the accepted lanes in order. Directed scenarios are followed by
// a randomized run.
// ---------------------------------------------------------------------------------------------
module tb_wired_inst_buffer;

   localparam int unsigned DEPTH  = 8;
   localparam int unsigned DATA_W = 72;
   localparam int unsigned CW     = $clog2(DEPTH) + 1;

   logic                clk = 1'b0;
   logic                rst;
   logic                flush_i;
   logic [1:0]          in_valid_i;
   logic [2*DATA_W-1:0] in_data_i;
   logic                in_ready_o;
   logic [1:0]          out_valid_o;
   logic [2*DATA_W-1:0] out_data_o;
   logic                out_ready_i;
   logic [CW-1:0]       count_o;

   int errors = 0;
   int checks = 0;

   logic [DATA_W-1:0] model_q[$];

   always #5 clk = ~clk;

   wired_inst_buffer #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .in_valid_i  (in_valid_i),
      .in_data_i   (in_data_i),
      .in_ready_o  (in_ready_o),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_ready_i (out_ready_i),
      .count_o     (count_o)
   );

   function automatic logic [DATA_W-1:0] rnd_word();
      logic [95:0] r;
      r = {$urandom, $urandom, $urandom};
      return r[DATA_W-1:0];
   endfunction

   task automatic drive(input logic r, input logic f, input logic [1:0] v,
                        input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1,
                        input logic rdy);
      rst         = r;
      flush_i     = f;
      in_valid_i  = v;
      in_data_i   = {d1, d0};
      out_ready_i = rdy;
   endtask

   // Advance one clock and update the reference queue from the inputs seen at that edge.
   task automatic tick();
      int  n_out;
      bit  room;
      @(posedge clk);
      if (rst || flush_i) begin
         model_q.delete();
      end else begin
         room  = (int'(DEPTH) - model_q.size()) >= 2;
         n_out = out_ready_i ? ((model_q.size() >= 2) ? 2 : model_q.size()) : 0;
         repeat (n_out) void'(model_q.pop_front());
         if (room) begin
            if (in_valid_i[0]) model_q.push_back(in_data_i[DATA_W-1:0]);
            if (in_valid_i[1]) model_q.push_back(in_data_i[2*DATA_W-1:DATA_W]);
         end
      end
      #1;
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
   endtask

   // T1
   task automatic test_reset();
      logic [DATA_W-1:0] a, b;
      do_reset();
      checks++;
      if (out_valid_o !== 2'b00) begin
         errors++; $display("FAIL reset_valid: got %b want 00", out_valid_o);
      end
      checks++;
      if (in_ready_o !== 1'b1) begin
         errors++; $display("FAIL reset_ready: got %b want 1", in_ready_o);
      end
      checks++;
      if (count_o !== CW'(0)) begin
         errors++; $display("FAIL reset_count: got %0d want 0", count_o);
      end
      a = rnd_word();
      b = rnd_word();
      drive(1'b0, 1'b0, 2'b11, a, b, 1'b0);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      checks++;
      if (out_valid_o !== 2'b11) begin
         errors++; $display("FAIL first_pkt_valid: got %b want 11", out_valid_o);
      end
      checks++;
      if (out_data_o !== {b, a}) begin
         errors++; $display("FAIL first_pkt_data: got %h want %h", out_data_o, {b, a});
      end
   endtask

   // T2
   task automatic test_compaction();
      logic [DATA_W-1:0] x, y;
      do_reset();
      x = rnd_word();
      y = rnd_word();
      drive(1'b0, 1'b0, 2'b10, rnd_word(), x, 1'b0);
      tick();
      drive(1'b0, 1'b0, 2'b01, y, rnd_word(), 1'b0);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      checks++;
      if (count_o !== CW'(2)) begin
         errors++; $display("FAIL compact_count: got %0d want 2", count_o);
      end
      checks++;
      if (out_valid_o !== 2'b11 || out_data_o !== {y, x}) begin
         errors++;
         $display("FAIL compact_data: got v=%b %h want v=11 %h", out_valid_o, out_data_o, {y, x});
      end
   endtask

   // T3
   task automatic test_fill();
      logic [DATA_W-1:0] w [8];
      do_reset();
      foreach (w[i]) w[i] = rnd_word();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 2'b11, w[2*i], w[2*i+1], 1'b0);
         tick();
      end
      checks++;
      if (count_o !== CW'(8) || in_ready_o !== 1'b0) begin
         errors++; $display("FAIL fill_full: got cnt=%0d rdy=%b want 8/0", count_o, in_ready_o);
      end
      drive(1'b0, 1'b0, 2'b11, rnd_word(), rnd_word(), 1'b0);
      tick();
      checks++;
      if (count_o !== CW'(8) || out_data_o !== {w[1], w[0]}) begin
         errors++;
         $display("FAIL fill_hold: got cnt=%0d %h want 8 %h", count_o, out_data_o, {w[1], w[0]});
      end
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      checks++;
      if (count_o !== CW'(6) || in_ready_o !== 1'b1) begin
         errors++; $display("FAIL fill_drain: got cnt=%0d rdy=%b want 6/1", count_o, in_ready_o);
      end
      checks++;
      if (out_data_o !== {w[3], w[2]}) begin
         errors++; $display("FAIL fill_order: got %h want %h", out_data_o, {w[3], w[2]});
      end
   endtask

   // T4: move rd_ptr to 2, preload seven entries so wr_ptr wraps to 1, then mix enq/deq.
   task automatic test_wrap_simultaneous();
      do_reset();
      drive(1'b0, 1'b0, 2'b11, rnd_word(), rnd_word(), 1'b0);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 2'b11, rnd_word(), rnd_word(), 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 2'b01, rnd_word(), rnd_word(), 1'b0);
      tick();
      checks++;
      if (count_o !== CW'(7) || in_ready_o !== 1'b0) begin
         errors++; $display("FAIL wrap_preload: got cnt=%0d rdy=%b want 7/0", count_o, in_ready_o);
      end
      // At cnt=7 the enqueue is held while two entries drain.
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 2'b01, rnd_word(), rnd_word(), 1'b1);
         tick();
         checks++;
         if (count_o !== CW'(model_q.size()) || out_data_o !== {model_q[1], model_q[0]}) begin
            errors++;
            $display("FAIL wrap_step%0d: got cnt=%0d %h want %0d %h", i, count_o, out_data_o,
                     model_q.size(), {model_q[1], model_q[0]});
         end
      end
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
   endtask

   // T5
   task automatic test_flush();
      do_reset();
      drive(1'b0, 1'b0, 2'b11, rnd_word(), rnd_word(), 1'b0);
      tick();
      tick();
      drive(1'b0, 1'b0, 2'b01, rnd_word(), rnd_word(), 1'b0);
      tick();
      checks++;
      if (count_o !== CW'(5)) begin
         errors++; $display("FAIL flush_pre: got %0d want 5", count_o);
      end
      drive(1'b0, 1'b1, 2'b11, rnd_word(), rnd_word(), 1'b1);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      checks++;
      if (count_o !== CW'(0) || out_valid_o !== 2'b00 || in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL flush_post: got cnt=%0d v=%b rdy=%b want 0/00/1",
                  count_o, out_valid_o, in_ready_o);
      end
      tick();
      checks++;
      if (out_valid_o !== 2'b00) begin
         errors++; $display("FAIL flush_drop: got v=%b want 00", out_valid_o);
      end
   endtask

   // T6
   task automatic test_reset_mid();
      logic [DATA_W-1:0] p, q;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 2'b11, rnd_word(), rnd_word(), 1'b0);
         tick();
      end
      drive(1'b1, 1'b1, 2'b11, rnd_word(), rnd_word(), 1'b1);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      checks++;
      if (count_o !== CW'(0) || out_valid_o !== 2'b00 || in_ready_o !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_state: got cnt=%0d v=%b rdy=%b want 0/00/1",
                  count_o, out_valid_o, in_ready_o);
      end
      p = rnd_word();
      q = rnd_word();
      drive(1'b0, 1'b0, 2'b11, p, q, 1'b0);
      tick();
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
      checks++;
      if (count_o !== CW'(2) || out_data_o !== {q, p}) begin
         errors++;
         $display("FAIL rstmid_pkt: got cnt=%0d %h want 2 %h", count_o, out_data_o, {q, p});
      end
   endtask

   task automatic test_random();
      logic [1:0] exp_v;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         drive(1'b0, ($urandom_range(0, 39) == 0), 2'($urandom), rnd_word(), rnd_word(),
               ($urandom_range(0, 2) == 0));
         tick();
         exp_v = {model_q.size() >= 2, model_q.size() >= 1};
         checks++;
         if (count_o !== CW'(model_q.size()) || out_valid_o !== exp_v ||
             in_ready_o !== (model_q.size() <= DEPTH - 2)) begin
            errors++;
            $display("FAIL rand_status@%0d: got cnt=%0d v=%b rdy=%b want cnt=%0d v=%b",
                     i, count_o, out_valid_o, in_ready_o, model_q.size(), exp_v);
         end
         if (model_q.size() >= 1) begin
            checks++;
            if (out_data_o[DATA_W-1:0] !== model_q[0]) begin
               errors++;
               $display("FAIL rand_lane0@%0d: got %h want %h", i, out_data_o[DATA_W-1:0],
                        model_q[0]);
            end
         end
         if (model_q.size() >= 2) begin
            checks++;
            if (out_data_o[2*DATA_W-1:DATA_W] !== model_q[1]) begin
               errors++;
               $display("FAIL rand_lane1@%0d: got %h want %h", i,
                        out_data_o[2*DATA_W-1:DATA_W], model_q[1]);
            end
         end
      end
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0);
   endtask

   initial begin
      drive(1'b1, 1'b0, 2'b00, '0, '0, 1'b0);
      test_reset();
      test_compaction();
      test_fill();
      test_wrap_simultaneous();
      test_flush();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
